// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter so that both ends of the link agree.
// This package holds the FSM state encoding, the frame width and the default bit period.
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

endpackage

// File: rtl/receiver_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input.
// Both flops reset to 1 (line idle) so that reset can never look like a start bit.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/receiver.sv
// Oversampling UART receiver (8N1) with a one-cycle valid or error strobe per frame.
// Define RX_PARITY_EN to expect one even-parity bit between the data bits and the stop bit.
module receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_err
);

    localparam int              CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   HALF_M1 = CW'((CLKS_PER_BIT >> 1) - 1);
    localparam logic [CW-1:0]   FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

    logic                 w_rxd;
    logic                 w_par_bad;
    rx_state_t            r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_err;
    logic                 w_tick;

    rx_sync u_rx_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rxd),
        .o_q (w_rxd)
    );

    // Every sampling point falls where the down-counter reaches zero.
    assign w_tick = (r_clk_cnt == '0);

`ifdef RX_PARITY_EN
    logic r_par_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_err <= 1'b0;
        end else if (r_state == ST_PARITY && w_tick) begin
            r_par_err <= w_rxd ^ (^r_shift);
        end
    end

    assign w_par_bad = r_par_err;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (!w_tick) begin
                r_clk_cnt <= r_clk_cnt - CNT_ONE;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxd) begin
                        r_state   <= ST_START;
                        r_bit_cnt <= '0;
                        r_clk_cnt <= HALF_M1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (!w_rxd) begin
                            r_state   <= ST_DATA;
                            r_clk_cnt <= FULL_M1;
                        end else begin
                            // Line came back high before mid-bit: treat as a glitch.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift   <= {w_rxd, r_shift[DATA_BITS-1:1]};
                        r_clk_cnt <= FULL_M1;
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state   <= ST_STOP;
                        r_clk_cnt <= FULL_M1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick) begin
                        if (w_rxd) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            if (w_par_bad) begin
                                r_err <= 1'b1;
                            end else begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_WAIT_HIGH;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line (break) must not be mistaken for a new start bit.
                    if (w_rxd) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data  = r_data;
    assign rx_valid = r_valid;
    assign rx_busy  = r_busy;
    assign rx_err   = r_err;

endmodule

// File: doc/receiver.md
# receiver

UART receive stage that pairs with the team's `transmitter` block: it consumes the serial `txd` stream (connected here as `rxd`), recovers 8N1 frames by oversampling, and presents each byte on a parallel bus with a one-cycle valid strobe. It sits between the serial pin (or a loopback from `transmitter`) and the host-side logic.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 4; half-bit point = `CLKS_PER_BIT >> 1`.
- `clk`  input  1  single system clock, all logic on rising edge.
- `rst`  input  1  reset; one clock; reset is asynchronous and active-low.
- `rxd`  input  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  output  8  last correctly received byte, LSB = first data bit.
- `rx_valid`  output  1  one-cycle pulse: `rx_data` updated this cycle.
- `rx_busy`  output  1  high whenever the FSM is not in IDLE.
- `rx_err`  output  1  one-cycle pulse on framing error (and on parity error when enabled).

## Operation
- `rxd` passes through a 2-flop synchronizer; synchronizer flops reset to 1 so reset never fakes a start bit.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP, WAIT_HIGH.
- IDLE: synchronized line low -> START, bit counter cleared, cycle counter loaded.
- START: at half-bit, sample; low -> DATA; high -> glitch, back to IDLE, no pulse.
- DATA: sample every `CLKS_PER_BIT` cycles, shift into the shift register LSB-first; after the 8th sample -> STOP (or PARITY).
- STOP: sample one bit period later; high -> `rx_data` <= shift register, `rx_valid` pulse, -> IDLE; low -> `rx_err` pulse, `rx_data` unchanged, -> WAIT_HIGH.
- WAIT_HIGH: stay until synchronized line high, then IDLE (prevents a break condition from retriggering).
- New start bits are accepted from IDLE in the cycle immediately after the stop sample; back-to-back frames with one stop bit are supported.
- Reset mid-frame: all state dropped immediately; partial byte discarded; no pulse.
- Reset values: `rx_data` = 8'h00, `rx_valid` = 0, `rx_busy` = 0, `rx_err` = 0; FSM = IDLE.

## Timing
- Counts are from the first `clk` edge on which `rxd` is low (cycle 0); synchronized low at cycle 2.
- Start sample: cycle 2 + H, where H = `CLKS_PER_BIT >> 1`.
- Data bit k (0..7): cycle 2 + H + (k+1)·`CLKS_PER_BIT`.
- Stop sample: cycle 2 + H + 9·`CLKS_PER_BIT` (+`CLKS_PER_BIT` with parity).
- `rx_valid` / `rx_err` are registered: high for exactly the cycle after the stop (or parity) decision.
- For `CLKS_PER_BIT`=16: start sample at cycle 10, data at 26..138, stop at 154, `rx_valid` at 155.
- `rx_busy` rises the cycle after the synchronized falling edge and falls with the transition back to IDLE.
- `rx_valid` and `rx_err` are never high together.

## Configuration
- `RX_PARITY_EN` defined: the PARITY state is compiled in; one even-parity bit is expected between the data and stop bits; a mismatch pulses `rx_err` at the stop decision, leaves `rx_data` unchanged, and moves to IDLE (or WAIT_HIGH if the stop bit is also low).
- Undefined: 8N1 only; the PARITY state and parity logic are absent.

## Structure
- Shared package `uart_pkg`: the FSM state encoding, the `DATA_BITS` = 8 constant, and the default `CLKS_PER_BIT`, shared with `transmitter` so both ends agree.
- One sub-module: `rx_sync`, a 2-flop synchronizer with asynchronous active-low reset to 1.
- Everything else (FSM, counters, shift register) lives in `receiver`.

## Test plan
- Hold `rst` low, toggle `rxd` -> `rx_data`=8'h00; `rx_valid`, `rx_busy` and `rx_err` all 0 throughout.
- Send frame 8'h12 (`CLKS_PER_BIT`=16) -> `rx_valid` high for one cycle at cycle 155, `rx_data`=8'h12, `rx_err`=0.
- Send 8'h34 then 8'h87 back-to-back, one stop bit -> two `rx_valid` pulses 160 cycles apart carrying 8'h34 then 8'h87; also run looped back from `transmitter`.
- Drive `rxd` low for 4 cycles only -> `rx_busy` pulses, returns to IDLE after the start sample, no `rx_valid`, no `rx_err`.
- Send 8'h55 with stop bit 0 and hold the line low for 40 cycles -> `rx_err` pulse, `rx_data` keeps the previous value, `rx_busy` stays high until the line returns high; assert `rst` mid-frame -> outputs return to reset values with no pulse.
- With `RX_PARITY_EN`: send 8'hA5 with parity bit 1 (wrong) -> `rx_err` pulse, no `rx_valid`; send it with parity bit 0 -> `rx_valid` and `rx_data`=8'hA5.
